// File: rtl/sal_traffic_gen.sv
// Write/read-back traffic generator and checker for the DDR controller request and AXI data ports.
// Each test writes num_bursts 32B accesses with a seeded pattern, then reads each one back and compares it.
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | waiting for start
// S_WR      | write request and two W beats of burst idx in flight
// S_RD_REQ  | read request for burst idx presented
// S_RD_DATA | accepting and checking the two read beats of burst idx
// S_DONE    | test finished, done/pass held until next start
module sal_traffic_gen #(
   parameter int ID_W  = 4,
   parameter int RA_W  = 14,
   parameter int CA_W  = 10,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_bursts,
   input  logic [31:0]       seed,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [CNT_W-1:0]  first_err_idx,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [ID_W-1:0]   req_id,
   output logic [RA_W-1:0]   req_ra,
   output logic [CA_W-1:0]   req_ca,
   output logic              req_wr,
   output logic [1:0]        req_len,
   output logic              wvalid,
   input  logic              wready,
   output logic [ID_W-1:0]   wid,
   output logic [127:0]      wdata,
   output logic [15:0]       wstrb,
   output logic              wlast,
   input  logic              rvalid,
   output logic              rready,
   input  logic [ID_W-1:0]   rid,
   input  logic [127:0]      rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR      = 3'd1;
   localparam logic [2:0] S_RD_REQ  = 3'd2;
   localparam logic [2:0] S_RD_DATA = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [2:0]       state;
   logic [CNT_W-1:0] idx;
   logic [CNT_W-1:0] n_bursts;
   logic [31:0]      seed_q;
   logic             req_sent;
   logic [1:0]       beat_cnt;
   logic             rd_beat;
   logic [CNT_W-1:0] err_cnt_q;
   logic [CNT_W-1:0] first_err_q;
   logic             err_seen;

   logic             req_fire;
   logic             w_fire;
   logic             last_burst;
   logic             wr_complete;
   logic             rd_bad;
   logic             can_start;

   function automatic logic [127:0] pattern(input logic [31:0] s,
                                            input logic [CNT_W-1:0] i,
                                            input logic b);
      logic [31:0] base;
      base = s + (32'(i) << 3) + (b ? 32'd4 : 32'd0);
      return {base + 32'd3, base + 32'd2, base + 32'd1, base};
   endfunction

   assign busy      = (state == S_WR) || (state == S_RD_REQ) || (state == S_RD_DATA);
   assign done      = (state == S_DONE);
   assign pass      = done && (err_cnt_q == '0);
   assign err_cnt   = err_cnt_q;
   assign first_err_idx = first_err_q;

   assign req_valid = ((state == S_WR) && !req_sent) || (state == S_RD_REQ);
   assign req_wr    = (state == S_WR);
   assign req_id    = idx[ID_W-1:0];
   assign req_ca    = {idx[CA_W-3:0], 2'b00};
   assign req_ra    = RA_W'(idx >> (CA_W - 2));
   assign req_len   = 2'd1;

   assign wvalid    = (state == S_WR) && (beat_cnt != 2'd2);
   assign wlast     = wvalid && (beat_cnt == 2'd1);
   assign wid       = idx[ID_W-1:0];
   assign wstrb     = 16'hFFFF;
   // Payload is zeroed outside WR so nothing leaks out of idle/reset.
   assign wdata     = wvalid ? pattern(seed_q, idx, beat_cnt[0]) : '0;

   assign rready    = (state == S_RD_DATA);

   assign req_fire    = req_valid && req_ready;
   assign w_fire      = wvalid && wready;
   assign last_burst  = ((idx + CNT_ONE) == n_bursts);
   assign wr_complete = (req_sent || req_fire) &&
                        ((beat_cnt == 2'd2) || ((beat_cnt == 2'd1) && w_fire));
   assign rd_bad      = (rdata != pattern(seed_q, idx, rd_beat)) || (rresp != 2'b00) ||
                        (rid != idx[ID_W-1:0]) || (rlast != rd_beat);
   assign can_start   = start && ((state == S_IDLE) || (state == S_DONE));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         idx         <= '0;
         n_bursts    <= '0;
         seed_q      <= '0;
         req_sent    <= 1'b0;
         beat_cnt    <= 2'd0;
         rd_beat     <= 1'b0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
         err_seen    <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (can_start) begin
                  n_bursts    <= num_bursts;
                  seed_q      <= seed;
                  idx         <= '0;
                  req_sent    <= 1'b0;
                  beat_cnt    <= 2'd0;
                  rd_beat     <= 1'b0;
                  err_cnt_q   <= '0;
                  first_err_q <= '0;
                  err_seen    <= 1'b0;
                  state       <= (num_bursts != '0) ? S_WR : S_DONE;
               end
            end
            S_WR: begin
               if (req_fire) req_sent <= 1'b1;
               if (w_fire)   beat_cnt <= beat_cnt + 2'd1;
               if (wr_complete) begin
                  req_sent <= 1'b0;
                  beat_cnt <= 2'd0;
                  if (last_burst) begin
                     idx   <= '0;
                     state <= S_RD_REQ;
                  end else begin
                     idx   <= idx + CNT_ONE;
                  end
               end
            end
            S_RD_REQ: begin
               if (req_fire) begin
                  rd_beat <= 1'b0;
                  state   <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               if (rvalid) begin
                  if (rd_bad) begin
                     if (err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + CNT_ONE;
                     if (!err_seen) begin
                        err_seen    <= 1'b1;
                        first_err_q <= idx;
                     end
                  end
                  rd_beat <= ~rd_beat;
                  // rlast closes the burst even if it arrives on the wrong beat.
                  if (rlast) begin
                     rd_beat <= 1'b0;
                     if (last_burst) begin
                        state <= S_DONE;
                     end else begin
                        idx   <= idx + CNT_ONE;
                        state <= S_RD_REQ;
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sal_traffic_gen.sv
// Self-checking bench for sal_traffic_gen: a memory model with optional backpressure and fault
// injection, a table of whole-test vectors, and hand-written sequences for reset and start corners.
module tb_sal_traffic_gen;
   localparam int ID_W = 4, RA_W = 14, CA_W = 10, CNT_W = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, start;
   logic [CNT_W-1:0]  num_bursts;
   logic [31:0]       seed;
   logic              busy, done, pass;
   logic [CNT_W-1:0]  err_cnt, first_err_idx;
   logic              req_valid, req_ready, req_wr;
   logic [ID_W-1:0]   req_id, wid, rid;
   logic [RA_W-1:0]   req_ra;
   logic [CA_W-1:0]   req_ca;
   logic [1:0]        req_len, rresp;
   logic              wvalid, wready, wlast, rvalid, rready, rlast;
   logic [127:0]      wdata, rdata;
   logic [15:0]       wstrb;

   sal_traffic_gen #(.ID_W(ID_W), .RA_W(RA_W), .CA_W(CA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .num_bursts(num_bursts), .seed(seed),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .first_err_idx(first_err_idx),
      .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id), .req_ra(req_ra),
      .req_ca(req_ca), .req_wr(req_wr), .req_len(req_len),
      .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
   );

   typedef struct {
      int          nb;
      logic [31:0] seed;
      int          bp;
      int          corrupt_idx;
      int          rresp_idx;
      int          exp_err;
      int          exp_first;
      logic        exp_pass;
   } vec_t;

   int checks = 0;
   int errors = 0;

   // memory model configuration and bookkeeping
   int           bp = 0;
   int           corrupt_idx = -1;
   int           rresp_idx = -1;
   logic [31:0]  m_seed = '0;
   int           wr_req_n = 0, wr_beat_n = 0, rd_req_n = 0, rd_done_n = 0;
   logic [127:0] mem [int];
   logic [127:0] cap_b1b0 = '0;
   logic [29:0]  cap256 = '0;
   bit           rd_pend = 0;
   int           rd_b = 0, rd_idx = 0, rd_key = 0;
   logic [ID_W-1:0] rd_id = '0;
   bit           st_req = 0, st_w = 0;
   logic [159:0] saved_req = '0, saved_w = '0;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] exp_beat(input logic [31:0] s, input int i, input int b);
      logic [127:0] r;
      for (int k = 0; k < 4; k++) r[32*k +: 32] = s + 32'(8*i + 4*b + k);
      return r;
   endfunction

   function automatic int exp_ca(input int i); return (i * 4) % (1 << CA_W); endfunction
   function automatic int exp_ra(input int i); return (i >> (CA_W - 2)) % (1 << RA_W); endfunction
   function automatic int exp_id(input int i); return i % (1 << ID_W); endfunction
   function automatic int key_of(input int ra, input int ca, input int b);
      return (ra << 11) | (ca << 1) | b;
   endfunction

   // Memory model: decides ready/response at each falling edge; the handshake lands on the next rising edge.
   initial begin
      req_ready = 0; wready = 0; rvalid = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            req_ready = 0; wready = 0; rvalid = 0; rlast = 0; rdata = '0; rresp = '0; rid = '0;
            rd_pend = 0; st_req = 0; st_w = 0;
            continue;
         end
         if (st_req) chk("req_hold", 160'({req_valid, req_wr, req_id, req_ra, req_ca}), saved_req);
         if (st_w)   chk("w_hold", 160'({wvalid, wlast, wid, wdata}), saved_w);
         req_ready = (bp == 0) ? 1'b1 : ($urandom_range(99) >= bp);
         wready    = (bp == 0) ? 1'b1 : ($urandom_range(99) >= bp);
         if (rd_pend && ((bp == 0) || ($urandom_range(99) >= bp))) begin
            rvalid = 1;
            rid    = rd_id;
            rlast  = (rd_b == 1);
            rdata  = mem.exists(rd_key + rd_b) ? mem[rd_key + rd_b] : '0;
            if (rd_idx == corrupt_idx && rd_b == 1) rdata = rdata ^ 128'h1;
            rresp  = (rd_idx == rresp_idx && rd_b == 0) ? 2'b10 : 2'b00;
         end else begin
            rvalid = 0; rlast = 0; rdata = '0; rresp = '0; rid = '0;
         end
         if (rvalid && rready) begin
            rd_b++;
            if (rd_b == 2) begin
               rd_pend = 0; rd_b = 0; rd_done_n++;
            end
         end
         if (req_valid && req_ready) begin
            if (req_wr) begin
               chk("wr_addr", 160'({req_id, req_ra, req_ca}),
                   160'({ID_W'(exp_id(wr_req_n)), RA_W'(exp_ra(wr_req_n)), CA_W'(exp_ca(wr_req_n))}));
               if (wr_req_n == 256) cap256 = 30'({req_ra, req_ca});
               wr_req_n++;
            end else begin
               chk("rd_addr", 160'({req_id, req_ra, req_ca}),
                   160'({ID_W'(exp_id(rd_req_n)), RA_W'(exp_ra(rd_req_n)), CA_W'(exp_ca(rd_req_n))}));
               rd_pend = 1; rd_b = 0; rd_idx = rd_req_n; rd_id = req_id;
               rd_key  = key_of(int'(req_ra), int'(req_ca), 0);
               rd_req_n++;
            end
         end
         if (wvalid && wready) begin
            int i, b;
            i = wr_beat_n / 2;
            b = wr_beat_n % 2;
            chk("wbeat", 160'({wlast, wid, wdata}),
                160'({(b == 1), ID_W'(exp_id(i)), exp_beat(m_seed, i, b)}));
            mem[key_of(exp_ra(i), exp_ca(i), b)] = wdata;
            if (i == 1 && b == 0) cap_b1b0 = wdata;
            wr_beat_n++;
         end
         st_req    = req_valid && !req_ready;
         saved_req = 160'({req_valid, req_wr, req_id, req_ra, req_ca});
         st_w      = wvalid && !wready;
         saved_w   = 160'({wvalid, wlast, wid, wdata});
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic clear_model(input int nbp, input logic [31:0] s, input int ci, input int ri);
      bp = nbp; m_seed = s; corrupt_idx = ci; rresp_idx = ri;
      wr_req_n = 0; wr_beat_n = 0; rd_req_n = 0; rd_done_n = 0;
      mem.delete();
   endtask

   task automatic pulse_start(input int nb, input logic [31:0] s);
      num_bursts = CNT_W'(nb);
      seed  = s;
      start = 1;
      step();
      start = 0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int k;
      k = 0;
      while (!done && k < budget) begin
         step();
         k++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s timeout done=%0b after %0d cycles", name, done, k);
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, 160'({busy, done, pass, req_valid, req_wr, wvalid, wlast, rready,
                      err_cnt, first_err_idx, req_id, req_ra, req_ca, wid}), '0);
      chk({name, "_wdata"}, 160'(wdata), '0);
      chk({name, "_const"}, 160'({wstrb, req_len}), 160'({16'hFFFF, 2'd1}));
   endtask

   vec_t vecs[4];

   initial begin
      vecs[0] = '{4,   32'h0000_0000, 0,  -1, -1, 0, 0, 1'b1};
      vecs[1] = '{300, 32'h1234_5678, 50, -1, -1, 0, 0, 1'b1};
      vecs[2] = '{16,  32'hFFFF_FFF0, 0,   5,  7, 2, 5, 1'b0};
      vecs[3] = '{3,   32'hDEAD_BEEF, 30, -1,  1, 1, 1, 1'b0};

      rst = 1; start = 0; num_bursts = '0; seed = '0;
      step(3);
      chk_all_zero("reset");
      rst = 0;
      step();

      for (int v = 0; v < 4; v++) begin
         clear_model(vecs[v].bp, vecs[v].seed, vecs[v].corrupt_idx, vecs[v].rresp_idx);
         pulse_start(vecs[v].nb, vecs[v].seed);
         chk($sformatf("start_lat_%0d", v), 160'({busy, req_valid, wvalid, req_wr, done}), 160'(5'b11110));
         wait_done($sformatf("vec_%0d", v), 20000);
         chk($sformatf("status_%0d", v), 160'({done, busy, pass}), 160'({1'b1, 1'b0, vecs[v].exp_pass}));
         chk($sformatf("err_cnt_%0d", v), 160'(err_cnt), 160'(vecs[v].exp_err));
         chk($sformatf("first_err_%0d", v), 160'(first_err_idx), 160'(vecs[v].exp_first));
         chk($sformatf("counts_%0d", v), 160'({wr_req_n, wr_beat_n, rd_done_n}),
             160'({vecs[v].nb, 2 * vecs[v].nb, vecs[v].nb}));
         if (v == 0) chk("b1b0", 160'(cap_b1b0), 160'(128'h0000000B_0000000A_00000009_00000008));
         if (v == 1) chk("idx256", 160'(cap256), 160'({14'd1, 10'd0}));
         step(2);
      end

      // start pulsed in DONE (previous test had an error): counters clear, fresh test runs
      clear_model(0, 32'h0000_0077, -1, -1);
      pulse_start(2, 32'h0000_0077);
      chk("restart_clear", 160'({busy, err_cnt, first_err_idx}), 160'({1'b1, 16'd0, 16'd0}));
      wait_done("restart", 2000);
      chk("restart_pass", 160'({done, pass, rd_done_n}), 160'({1'b1, 1'b1, 32'd2}));

      // zero-length test goes straight to DONE with pass and no request
      clear_model(0, 32'h0, -1, -1);
      pulse_start(0, 32'h0);
      chk("zero_nb", 160'({done, pass, req_valid, busy}), 160'(4'b1100));
      step();
      chk("zero_nb_noreq", 160'(wr_req_n), 160'(0));

      // start pulsed during RD_DATA with different parameters must be ignored
      clear_model(0, 32'h0000_1000, -1, -1);
      pulse_start(4, 32'h0000_1000);
      begin
         int k;
         k = 0;
         while (!rready && k < 200) begin
            step();
            k++;
         end
         chk("reach_rd_data", 160'(rready), 160'(1));
      end
      num_bursts = 16'd9; seed = 32'h0; start = 1;
      step();
      start = 0;
      wait_done("start_in_rd", 2000);
      chk("start_in_rd", 160'({pass, err_cnt, wr_req_n, rd_done_n}),
          160'({1'b1, 16'd0, 32'd4, 32'd4}));

      // reset in the middle of burst 2 of the write phase
      clear_model(0, 32'h5555_0000, -1, -1);
      pulse_start(8, 32'h5555_0000);
      begin
         int k;
         k = 0;
         while (wr_req_n < 3 && k < 200) begin
            step();
            k++;
         end
         chk("reach_burst2", 160'({busy, req_wr, req_id}), 160'({1'b1, 1'b1, 4'd2}));
      end
      rst = 1;
      step();
      chk_all_zero("mid_reset");
      rst = 0;
      step();
      clear_model(0, 32'hA5A5_0000, -1, -1);
      pulse_start(8, 32'hA5A5_0000);
      wait_done("after_reset", 2000);
      chk("after_reset", 160'({done, pass, err_cnt, rd_done_n}), 160'({1'b1, 1'b1, 16'd0, 32'd8}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
